// File: rtl/mem_stage.sv
// Memory-access stage: turns EXE results into a data-memory req/ack access or a direct writeback.
// Optional ACCESS watchdog with error pulse when MEM_TIMEOUT_EN is defined.
module mem_stage #(
    parameter int ARQ      = 16,
    parameter int MEM_ADDR = 13
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_enable_in,
    input  logic                rd_mem_in,
    input  logic                wr_mem_in,
    input  logic                mux_mem_in,
    input  logic [ARQ-1:0]      addr_in,
    input  logic [ARQ-1:0]      store_data_in,
    input  logic [ARQ-1:0]      wb_imm_in,
    input  logic [2:0]          wb_dest_in,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [MEM_ADDR-1:0] dmem_addr,
    output logic [ARQ-1:0]      dmem_wdata,
    input  logic [ARQ-1:0]      dmem_rdata,
    input  logic                dmem_ack,
    output logic                stall_out,
    output logic                wb_enable_out,
    output logic [2:0]          wb_dest_out,
    output logic [ARQ-1:0]      wb_data_out,
    output logic                mem_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [MEM_ADDR-1:0] addr_q, addr_d;
    logic                we_q, we_d;
    logic [ARQ-1:0]      wdata_q, wdata_d;
    logic [2:0]          dest_q, dest_d;
    logic                wben_q, wben_d;
    logic                wb_en_q, wb_en_d;
    logic [2:0]          wb_dest_q, wb_dest_d;
    logic [ARQ-1:0]      wb_data_q, wb_data_d;

    logic access_req;
    logic abort;

    assign access_req = rd_mem_in | wr_mem_in;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Abort on the TIMEOUT_CYCLES-th ACCESS cycle without ack; an ack in that cycle wins.
    assign abort = (state_q == S_ACCESS) && !dmem_ack
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        err_d = 1'b0;
        if (state_q == S_ACCESS) begin
            if (!dmem_ack && !abort) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            err_d = abort;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        dest_d    = dest_q;
        wben_d    = wben_q;
        wb_en_d   = 1'b0;
        wb_dest_d = '0;
        wb_data_d = '0;
        case (state_q)
            S_IDLE: begin
                if (access_req) begin
                    // rd+wr together is a load, so the write strobe needs wr alone.
                    addr_d  = addr_in[MEM_ADDR-1:0];
                    we_d    = wr_mem_in & ~rd_mem_in;
                    wdata_d = store_data_in;
                    dest_d  = wb_dest_in;
                    wben_d  = wb_enable_in;
                    state_d = S_ACCESS;
                end else if (wb_enable_in) begin
                    wb_en_d   = 1'b1;
                    wb_dest_d = wb_dest_in;
                    wb_data_d = mux_mem_in ? wb_imm_in : addr_in;
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    if (!we_q && wben_q) begin
                        wb_en_d   = 1'b1;
                        wb_dest_d = dest_q;
                        wb_data_d = dmem_rdata;
                    end
                end else if (abort) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dest_q    <= '0;
            wben_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
            wben_q    <= wben_d;
            wb_en_q   <= wb_en_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign dmem_req      = (state_q == S_ACCESS);
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign stall_out     = (state_q == S_IDLE) ? access_req : ~(dmem_ack | abort);
    assign wb_enable_out = wb_en_q;
    assign wb_dest_out   = wb_dest_q;
    assign wb_data_out   = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction stream.
// Timeout scenario is built only when MEM_TIMEOUT_EN is defined (limit overridden to 8).
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        wb_enable_in, rd_mem_in, wr_mem_in, mux_mem_in;
    logic [15:0] addr_in, store_data_in, wb_imm_in;
    logic [2:0]  wb_dest_in;
    logic        dmem_req, dmem_we;
    logic [12:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_out, wb_enable_out;
    logic [2:0]  wb_dest_out;
    logic [15:0] wb_data_out;
    logic        mem_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(
        .ARQ(16),
        .MEM_ADDR(13)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_enable_in), .rd_mem_in(rd_mem_in), .wr_mem_in(wr_mem_in),
        .mux_mem_in(mux_mem_in), .addr_in(addr_in), .store_data_in(store_data_in),
        .wb_imm_in(wb_imm_in), .wb_dest_in(wb_dest_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .wb_enable_out(wb_enable_out),
        .wb_dest_out(wb_dest_out), .wb_data_out(wb_data_out), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_nop();
        wb_enable_in = 0; rd_mem_in = 0; wr_mem_in = 0; mux_mem_in = 0;
        addr_in = 0; store_data_in = 0; wb_imm_in = 0; wb_dest_in = 0;
    endtask

    // Non-memory instruction: registered writeback one cycle later, never stalls.
    task automatic alu_op(input logic en, input logic [2:0] dest, input logic [15:0] addr,
                          input logic mux, input logic [15:0] imm, input string name);
        logic        exp_en;
        logic [2:0]  exp_dest;
        logic [15:0] exp_data;
        exp_en   = en;
        exp_dest = en ? dest : 3'd0;
        exp_data = en ? (mux ? imm : addr) : 16'd0;
        wb_enable_in = en; rd_mem_in = 0; wr_mem_in = 0; mux_mem_in = mux;
        addr_in = addr; wb_imm_in = imm; wb_dest_in = dest; store_data_in = 16'($urandom);
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = 16'($urandom);
        #1;
        n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL %s stall: got %b want 0", name, stall_out); end
        @(posedge clk); #1;
        dmem_ack = 0;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL %s req: got %b want 0", name, dmem_req); end
        n_cmp++; if (wb_enable_out !== exp_en) begin n_err++; $display("FAIL %s wb_en: got %b want %b", name, wb_enable_out, exp_en); end
        n_cmp++; if (wb_dest_out !== exp_dest) begin n_err++; $display("FAIL %s wb_dest: got %0d want %0d", name, wb_dest_out, exp_dest); end
        n_cmp++; if (wb_data_out !== exp_data) begin n_err++; $display("FAIL %s wb_data: got %h want %h", name, wb_data_out, exp_data); end
        drive_nop();
        $display("txn %s alu en=%b dest=%0d data=%h", name, exp_en, exp_dest, exp_data);
    endtask

    // Memory instruction; ack arrives after 'delay' ACCESS cycles without ack.
    task automatic mem_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] sdata, input logic [2:0] dest, input logic en,
                          input int delay, input logic [15:0] rdata, input string name);
        logic        is_store;
        logic [12:0] exp_addr;
        logic        exp_en;
        logic [2:0]  exp_dest;
        logic [15:0] exp_data;
        is_store = wr && !rd;
        exp_addr = addr[12:0];
        exp_en   = !is_store && en;
        exp_dest = exp_en ? dest : 3'd0;
        exp_data = exp_en ? rdata : 16'd0;
        wb_enable_in = en; rd_mem_in = rd; wr_mem_in = wr; mux_mem_in = 1'($urandom);
        addr_in = addr; store_data_in = sdata; wb_imm_in = 16'($urandom); wb_dest_in = dest;
        dmem_ack = 0;
        #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL %s stall0: got %b want 1", name, stall_out); end
        @(posedge clk); #1;
        for (int k = 0; k <= delay; k++) begin
            if (k == delay) begin dmem_ack = 1; dmem_rdata = rdata; end
            else begin dmem_ack = 0; dmem_rdata = 16'($urandom); end
            #1;
            n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL %s req c%0d: got %b want 1", name, k + 1, dmem_req); end
            n_cmp++; if (dmem_addr !== exp_addr) begin n_err++; $display("FAIL %s addr c%0d: got %h want %h", name, k + 1, dmem_addr, exp_addr); end
            n_cmp++; if (dmem_we !== is_store) begin n_err++; $display("FAIL %s we c%0d: got %b want %b", name, k + 1, dmem_we, is_store); end
            if (is_store) begin
                n_cmp++; if (dmem_wdata !== sdata) begin n_err++; $display("FAIL %s wdata c%0d: got %h want %h", name, k + 1, dmem_wdata, sdata); end
            end
            n_cmp++; if (stall_out !== (k != delay)) begin n_err++; $display("FAIL %s stall c%0d: got %b want %b", name, k + 1, stall_out, k != delay); end
            n_cmp++; if (wb_enable_out !== 1'b0) begin n_err++; $display("FAIL %s wb_en c%0d: got %b want 0", name, k + 1, wb_enable_out); end
            @(posedge clk); #1;
        end
        dmem_ack = 0;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL %s req after ack: got %b want 0", name, dmem_req); end
        n_cmp++; if (wb_enable_out !== exp_en) begin n_err++; $display("FAIL %s wb_en: got %b want %b", name, wb_enable_out, exp_en); end
        n_cmp++; if (wb_dest_out !== exp_dest) begin n_err++; $display("FAIL %s wb_dest: got %0d want %0d", name, wb_dest_out, exp_dest); end
        n_cmp++; if (wb_data_out !== exp_data) begin n_err++; $display("FAIL %s wb_data: got %h want %h", name, wb_data_out, exp_data); end
        $display("txn %s mem rd=%b wr=%b addr=%h delay=%0d wb_en=%b data=%h", name, rd, wr, exp_addr, delay, exp_en, exp_data);
    endtask

    task automatic test_reset();
        rst = 0; drive_nop(); dmem_ack = 0; dmem_rdata = 0;
        #3;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset req: got %b want 0", dmem_req); end
        n_cmp++; if (dmem_we !== 1'b0 || dmem_addr !== 13'd0 || dmem_wdata !== 16'd0) begin
            n_err++; $display("FAIL reset dmem: got we=%b addr=%h wdata=%h want 0", dmem_we, dmem_addr, dmem_wdata); end
        n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset stall: got %b want 0", stall_out); end
        n_cmp++; if (wb_enable_out !== 1'b0 || wb_dest_out !== 3'd0 || wb_data_out !== 16'd0) begin
            n_err++; $display("FAIL reset wb: got en=%b dest=%0d data=%h want 0", wb_enable_out, wb_dest_out, wb_data_out); end
        n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset mem_err: got %b want 0", mem_err); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_directed();
        alu_op(1'b1, 3'd3, 16'h1234, 1'b0, 16'h5555, "alu_basic");
        mem_op(1'b1, 1'b0, 16'h0042, 16'h0000, 3'd5, 1'b1, 2, 16'hBEEF, "load_basic");
        mem_op(1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 3'd2, 1'b1, 1, 16'h1111, "store_basic");
        mem_op(1'b1, 1'b1, 16'h2345, 16'h7777, 3'd6, 1'b1, 0, 16'hC0DE, "rd_wr_both");
        alu_op(1'b1, 3'd1, 16'h4321, 1'b1, 16'h00FF, "alu_imm");
        alu_op(1'b0, 3'd4, 16'h9999, 1'b0, 16'h0000, "alu_no_wb");
    endtask

    task automatic test_back_to_back();
        mem_op(1'b1, 1'b0, 16'h0100, 16'h0, 3'd1, 1'b1, 0, 16'h1001, "b2b_ld0");
        mem_op(1'b1, 1'b0, 16'h0101, 16'h0, 3'd2, 1'b1, 0, 16'h1002, "b2b_ld1");
        mem_op(1'b0, 1'b1, 16'h0102, 16'h3003, 3'd3, 1'b1, 0, 16'h0, "b2b_st2");
        alu_op(1'b1, 3'd7, 16'hABCD, 1'b0, 16'h0, "b2b_alu");
    endtask

    task automatic test_reset_mid_access();
        wb_enable_in = 1; rd_mem_in = 1; wr_mem_in = 0; addr_in = 16'h0077; wb_dest_in = 3'd4;
        dmem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid pre req: got %b want 1", dmem_req); end
        rst = 0; drive_nop();
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid req: got %b want 0", dmem_req); end
        n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rst_mid stall: got %b want 0", stall_out); end
        dmem_ack = 1; dmem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        dmem_ack = 0;
        n_cmp++; if (wb_enable_out !== 1'b0) begin n_err++; $display("FAIL rst_mid wb_en: got %b want 0", wb_enable_out); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        n_cmp++; if (wb_enable_out !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++; $display("FAIL rst_mid release: got wb_en=%b req=%b want 0", wb_enable_out, dmem_req); end
        $display("txn rst_mid reset during access");
        alu_op(1'b1, 3'd2, 16'h0F0F, 1'b0, 16'h0, "rst_mid_alu");
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        wb_enable_in = 1; rd_mem_in = 1; wr_mem_in = 0; addr_in = 16'h0333; wb_dest_in = 3'd5;
        dmem_ack = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL timeout req c%0d: got %b want 1", c, dmem_req); end
            n_cmp++; if (stall_out !== (c < 8)) begin n_err++; $display("FAIL timeout stall c%0d: got %b want %b", c, stall_out, c < 8); end
            n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL timeout err c%0d: got %b want 0", c, mem_err); end
            @(posedge clk); #1;
        end
        drive_nop();
        n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL timeout err pulse: got %b want 1", mem_err); end
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL timeout req drop: got %b want 0", dmem_req); end
        n_cmp++; if (wb_enable_out !== 1'b0) begin n_err++; $display("FAIL timeout wb_en: got %b want 0", wb_enable_out); end
        @(posedge clk); #1;
        n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL timeout err width: got %b want 0", mem_err); end
        $display("txn timeout abort");
        alu_op(1'b1, 3'd6, 16'h6006, 1'b0, 16'h0, "timeout_alu");
        mem_op(1'b1, 1'b0, 16'h0444, 16'h0, 3'd3, 1'b1, 7, 16'h4444, "ack_at_limit");
        n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL ack_at_limit err: got %b want 0", mem_err); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: alu_op(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), "rnd_alu");
                1: mem_op(1'b1, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                          int'($urandom_range(0, 4)), 16'($urandom), "rnd_load");
                2: mem_op(1'b0, 1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                          int'($urandom_range(0, 4)), 16'($urandom), "rnd_store");
                default: mem_op(1'b1, 1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                                int'($urandom_range(0, 4)), 16'($urandom), "rnd_both");
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
